// File: rtl/decoded_data_regs_pkg.sv
// Shared types and helpers for the decoded_data_regs AXI4-Lite register block:
// register count, register indices, AXI response codes and byte-lane merge.
package decoded_data_regs_pkg;

    localparam int NUM_REGS = 4;
    localparam int DATA_W   = 32;

    localparam logic [3:0] REG0_IDX = 4'd0;
    localparam logic [3:0] REG1_IDX = 4'd1;
    localparam logic [3:0] REG2_IDX = 4'd2;
    localparam logic [3:0] REG3_IDX = 4'd3;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    // Replace each byte lane of old_val with new_val where its strobe bit is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_val[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoded_data_regs_if.sv
// AXI4-Lite bus bundle for decoded_data_regs, with master and slave views.
interface decoded_data_regs_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic [2:0]          s_axi_awprot;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    logic [ADDR_W-1:0]   s_axi_araddr;
    logic [2:0]          s_axi_arprot;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [DATA_W-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rvalid;
    logic                s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/decoded_data_regs_wstrb_merge.sv
// Combinational byte-lane merge of incoming write data into a register value.
module decoded_data_regs_wstrb_merge
    import decoded_data_regs_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  strb_i,
    output logic [31:0] merged_o
);

    // Lane-wise select between stored and incoming bytes.
    always_comb begin
        merged_o = strb_merge(old_i, new_i, strb_i);
    end

endmodule

// File: rtl/decoded_data_regs.sv
// AXI4-Lite responder with four 32-bit registers driven into the fabric plus
// per-register write pulses. Define DECODED_DATA_REGS_SLVERR_EN to answer
// unimplemented indices with SLVERR instead of OKAY.
module decoded_data_regs
    import decoded_data_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    decoded_data_regs_if.slave       s_axi,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

`ifdef DECODED_DATA_REGS_SLVERR_EN
    localparam axi_resp_e UNIMPL_RESP = RESP_SLVERR;
`else
    localparam axi_resp_e UNIMPL_RESP = RESP_OKAY;
`endif

    logic                          aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]                    wstrb_q, wstrb_d;
    logic                          awready_q, awready_d, wready_q, wready_d;
    logic                          bvalid_q, bvalid_d;
    axi_resp_e                     bresp_q, bresp_d;
    logic                          arready_q, arready_d, rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    axi_resp_e                     rresp_q, rresp_d;
    logic [31:0]                   regs_q [NUM_REGS];
    logic [31:0]                   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]           wr_pulse_q, wr_pulse_d;

    logic                          aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic                          wimpl_s, rimpl_s;
    logic [C_S_AXI_ADDR_WIDTH-1:0] waddr_s;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_s;
    logic [3:0]                    wstrb_s, widx_s, ridx_s;
    logic [31:0]                   merged_s;
    logic                          unused_s;

    decoded_data_regs_wstrb_merge u_merge (
        .old_i    (regs_q[widx_s[1:0]]),
        .new_i    (wdata_s),
        .strb_i   (wstrb_s),
        .merged_o (merged_s)
    );

    // Next-state logic for both AXI channels and the register file.
    always_comb begin
        aw_hs_s  = s_axi.s_axi_awvalid && awready_q;
        w_hs_s   = s_axi.s_axi_wvalid && wready_q;
        ar_hs_s  = s_axi.s_axi_arvalid && arready_q;
        waddr_s  = aw_held_q ? awaddr_q : s_axi.s_axi_awaddr;
        wdata_s  = w_held_q ? wdata_q : s_axi.s_axi_wdata;
        wstrb_s  = w_held_q ? wstrb_q : s_axi.s_axi_wstrb;
        widx_s   = waddr_s[5:2];
        ridx_s   = s_axi.s_axi_araddr[5:2];
        wimpl_s  = (widx_s <= REG3_IDX);
        rimpl_s  = (ridx_s <= REG3_IDX);
        commit_s = (aw_held_q || aw_hs_s) && (w_held_q || w_hs_s);

        // A half-arrived write parks here until its partner channel shows up.
        aw_held_d = commit_s ? 1'b0 : (aw_held_q || aw_hs_s);
        w_held_d  = commit_s ? 1'b0 : (w_held_q || w_hs_s);
        awaddr_d  = aw_hs_s ? s_axi.s_axi_awaddr : awaddr_q;
        wdata_d   = w_hs_s ? s_axi.s_axi_wdata : wdata_q;
        wstrb_d   = w_hs_s ? s_axi.s_axi_wstrb : wstrb_q;

        if (commit_s) begin
            bvalid_d = 1'b1;
            bresp_d  = wimpl_s ? RESP_OKAY : UNIMPL_RESP;
        end else if (bvalid_q && s_axi.s_axi_bready) begin
            bvalid_d = 1'b0;
            bresp_d  = bresp_q;
        end else begin
            bvalid_d = bvalid_q;
            bresp_d  = bresp_q;
        end
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;

        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_s && wimpl_s && (widx_s[1:0] == 2'(i))) begin
                regs_d[i]     = merged_s;
                wr_pulse_d[i] = 1'b1;
            end else begin
                regs_d[i]     = regs_q[i];
                wr_pulse_d[i] = 1'b0;
            end
        end

        // Reads sample regs_q, so a same-cycle write is not yet visible.
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = rimpl_s ? regs_q[ridx_s[1:0]] : 32'd0;
            rresp_d  = rimpl_s ? RESP_OKAY : UNIMPL_RESP;
        end else if (rvalid_q && s_axi.s_axi_rready) begin
            rvalid_d = 1'b0;
            rdata_d  = rdata_q;
            rresp_d  = rresp_q;
        end else begin
            rvalid_d = rvalid_q;
            rdata_d  = rdata_q;
            rresp_d  = rresp_q;
        end
        arready_d = !rvalid_d;
    end

    // State registers; reset drops any in-flight transfer.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= 4'd0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Flattened register contents toward the fabric.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[32*i +: 32] = regs_q[i];
        end
    end

    assign wr_pulse_o          = wr_pulse_q;
    assign s_axi.s_axi_awready = awready_q;
    assign s_axi.s_axi_wready  = wready_q;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign s_axi.s_axi_arready = arready_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = rresp_q;

    assign unused_s = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                        waddr_s[1:0], s_axi.s_axi_araddr[1:0]};

endmodule

// File: doc/decoded_data_regs.md
# decoded_data_regs

AXI4-Lite responder exposing four 32-bit read/write registers to the processing system and driving their contents, plus a per-register write pulse, into the decoded-data fabric. It sits behind the block design's AXI interconnect, answering the same AXI4-Lite single-beat transactions the verification master issues. It is the slave-side counterpart to the sequential write-then-readback traffic used in the team's AXI VIP benches.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; decodes a 16-word window, of which 4 words are implemented.
- ACLK  in  1  clock; all logic is rising-edge.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- s_axi_awaddr / awprot / awvalid / awready  in,in,in,out  6,3,1,1  write address channel; awprot ignored.
- s_axi_wdata / wstrb / wvalid / wready  in,in,in,out  32,4,1,1  write data channel.
- s_axi_bresp / bvalid / bready  out,out,in  2,1,1  write response.
- s_axi_araddr / arprot / arvalid / arready  in,in,in,out  6,3,1,1  read address; arprot ignored.
- s_axi_rdata / rresp / rvalid / rready  out,out,out,in  32,2,1,1  read data.
- regs_o  out  128  register contents, reg n at [32n+31:32n].
- wr_pulse_o  out  4  one-cycle pulse, bit n high in the cycle after reg n is written.

## Operation
- Word index = addr[5:2]; addr[1:0] ignored. Indices 0-3 map to reg0-reg3; 4-15 unimplemented.
- Write path: AW and W accepted independently, in either order or same cycle; each is held until its partner arrives.
- awready = !aw_held && !bvalid; wready = !w_held && !bvalid. At most one write outstanding.
- Commit when both address and data are available (held or handshaking this cycle): byte lane k of the target register updated iff wstrb[k]; all-zero wstrb updates nothing but still responds.
- Unimplemented write index: no register changes, wr_pulse_o stays 0.
- Read path: arready = !rvalid; on handshake rdata/rresp are registered; unimplemented index reads 0.
- bresp/rresp = OKAY (2'b00) except as given in Configuration.
- Read and write to the same register committing in the same cycle: read returns the pre-write value.

## Timing
- Reset: awready, wready, arready = 0 while ARESETN low; they go to 1 on the first edge after release. bvalid, rvalid, wr_pulse_o = 0; bresp, rresp, rdata = 0; regs_o = 0; held AW/W flags cleared.
- Write latency: commit edge sets register, bvalid and wr_pulse_o; all visible the cycle after the last of AW/W handshakes. wr_pulse_o lasts exactly one cycle.
- bvalid held with stable bresp until bready; clears on the bvalid&&bready edge; the next AW/W can be accepted in the following cycle.
- Read latency: rvalid rises the cycle after the AR handshake; rdata/rresp stable until rready; back-to-back reads give at most one read per 2 cycles.
- Read and write channels are fully independent; simultaneous activity needs no arbitration.
- Reset asserted mid-transaction: in-flight transfer dropped, no response issued, registers cleared.

## Configuration
- DECODED_DATA_REGS_SLVERR_EN defined: accesses to indices 4-15 return SLVERR (2'b10) on bresp/rresp; timing unchanged.
- Undefined: those accesses return OKAY; writes are discarded, reads return 0.

## Structure
- Shared package decoded_data_regs_pkg: register count (4), index localparams REG0_IDX..REG3_IDX, AXI response enum (OKAY, SLVERR), and the byte-strobe merge function.
- Optional sub-module decoded_data_regs_wstrb_merge (combinational byte-lane merge); the AXI FSMs stay in the top.

## Test plan
- Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> rdata 0x1..0x4, all responses OKAY, regs_o = 0x00000004_00000003_00000002_00000001.
- W presented 3 cycles before AW to 0x8, data 0xDEADBEEF -> wready high then low, commit one cycle after AW handshake, wr_pulse_o = 4'b0100 for one cycle.
- Reg0 = 0xFFFFFFFF, write 0x12345678 with wstrb 4'b0101 -> reg0 reads 0xFF34FF78.
- bready held low 10 cycles after a write -> bvalid stays high, awready/wready stay 0; a second AW waits until after the B handshake.
- Read 0x10 -> rdata 0; rresp SLVERR with DECODED_DATA_REGS_SLVERR_EN, OKAY without.
- Assert ARESETN low after AW handshake but before W -> no bvalid afterwards, regs_o = 0, ready signals low during reset and high one cycle after release.
